// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: issues aligned word requests with byte
// lanes, formats load data, stalls the pipeline, and flags faults and timeouts.
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MEM_READ,
  input  logic        MEM_WRITE,
  input  logic [2:0]  FUNC3,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITE_DATA,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  output logic [3:0]  MEM_BYTE_EN,
  output logic        MEM_RD_REQ,
  output logic        MEM_WR_REQ,
  input  logic        MEM_READY,
  input  logic [31:0] MEM_RDATA,
  output logic [31:0] READ_DATA,
  output logic        BUSY,
  output logic        FAULT,
  output logic        BUS_ERROR
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             is_ld;
  logic             is_st;
  logic             req;
  logic             legal;
  logic             start;
  logic             timeout_hit;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       func3_p1;
  logic [1:0]       ofs_p1;

  function automatic logic f3_legal(input logic ld, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3)
      3'b000, 3'b001, 3'b010: ok = 1'b1;
      3'b100, 3'b101:         ok = ld;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic aligned(input logic [2:0] f3, input logic [1:0] ofs);
    logic ok;
    ok = 1'b1;
    case (f3[1:0])
      2'b01:   ok = ~ofs[0];
      2'b10:   ok = (ofs == 2'b00);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] lane_en(input logic ld, input logic [2:0] f3,
                                         input logic [1:0] ofs);
    logic [3:0] en;
    en = 4'b1111;
    if (!ld) begin
      case (f3[1:0])
        2'b00:   en = 4'b0001 << ofs;
        2'b01:   en = 4'b0011 << {ofs[1], 1'b0};
        default: en = 4'b1111;
      endcase
    end
    return en;
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (f3[1:0])
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Shift the addressed lane down to bit 0, then extend by the access type.
  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] ofs,
                                           input logic [31:0] word);
    logic        [31:0] lane;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] ext;
    lane = word >> {ofs, 3'b000};
    b    = lane[7:0];
    h    = lane[15:0];
    case (f3)
      3'b000:  ext = {{24{b[7]}}, b};
      3'b001:  ext = {{16{h[15]}}, h};
      3'b100:  ext = {24'd0, lane[7:0]};
      3'b101:  ext = {16'd0, lane[15:0]};
      default: ext = word;
    endcase
    return $unsigned(ext);
  endfunction

  // Request decode; a simultaneous read and write is treated as a load.
  assign is_ld       = MEM_READ;
  assign is_st       = MEM_WRITE & ~MEM_READ;
  assign req         = MEM_READ | MEM_WRITE;
  assign legal       = req & f3_legal(is_ld, FUNC3) & aligned(FUNC3, ADDRESS[1:0]);
  assign start       = (state == IDLE) & legal;
  assign timeout_hit = (cnt == CNT_LAST);

  assign FAULT = (state == IDLE) & req & ~legal;
  assign BUSY  = start | (state == ACCESS);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (legal) state_nxt = ACCESS;
      ACCESS:  if (MEM_READY || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // p0 -> p1: request launch in IDLE, completion or abort in ACCESS.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      MEM_ADDR    <= '0;
      MEM_WDATA   <= '0;
      MEM_BYTE_EN <= '0;
      MEM_RD_REQ  <= 1'b0;
      MEM_WR_REQ  <= 1'b0;
      READ_DATA   <= '0;
      BUS_ERROR   <= 1'b0;
      cnt         <= '0;
      func3_p1    <= '0;
      ofs_p1      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            MEM_ADDR    <= {ADDRESS[31:2], 2'b00};
            MEM_BYTE_EN <= lane_en(is_ld, FUNC3, ADDRESS[1:0]);
            if (is_st) MEM_WDATA <= lane_wdata(FUNC3, WRITE_DATA);
            MEM_RD_REQ  <= is_ld;
            MEM_WR_REQ  <= is_st;
            func3_p1    <= FUNC3;
            ofs_p1      <= ADDRESS[1:0];
            cnt         <= '0;
          end
        end
        ACCESS: begin
          if (MEM_READY) begin
            if (MEM_RD_REQ) READ_DATA <= fmt_load(func3_p1, ofs_p1, MEM_RDATA);
            MEM_RD_REQ <= 1'b0;
            MEM_WR_REQ <= 1'b0;
          end else if (timeout_hit) begin
            if (MEM_RD_REQ) READ_DATA <= '0;
            MEM_RD_REQ <= 1'b0;
            MEM_WR_REQ <= 1'b0;
            BUS_ERROR  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          BUS_ERROR <= 1'b0;
        end
        default: begin
          BUS_ERROR <= 1'b0;
        end
      endcase
    end
  end

endmodule
